load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: decodes a memory instruction, runs one single-beat bus access
// with a timeout, and returns sign/zero-extended load data to the writeback path.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] mem_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] calc_wstrb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] strb;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = 4'b0011 << off;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] rep;
        case (f3[1:0])
            2'b00:   rep = {4{wd[7:0]}};
            2'b01:   rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

    // Lane select by byte offset, then extend according to size and signedness.
    function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [2:0]       f3_q, f3_d;
    logic             store_q, store_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic             is_load_s, is_store_s, mem_op_s;

    assign is_load_s  = (opcode == OP_LOAD);
    assign is_store_s = (opcode == OP_STORE);
    assign mem_op_s   = is_load_s | is_store_s;

    // Next-state and datapath capture for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        f3_d       = f3_q;
        store_d    = store_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: begin
                if (start && mem_op_s) begin
                    addr_d  = addr;
                    f3_d    = funct3;
                    store_d = is_store_s;
                    wdata_d = calc_wdata(funct3, wdata);
                    wstrb_d = is_store_s ? calc_wstrb(funct3, addr[1:0]) : 4'b0000;
                    if (f3_legal(is_store_s, funct3) && !misaligned(funct3, addr[1:0])) begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = DONE;
                    if (!store_q) begin
                        mem_data_d = load_extend(bus_rdata, f3_q, addr_q[1:0]);
                    end else begin
                        mem_data_d = mem_data_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured-access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'b0000;
            f3_q       <= 3'b000;
            store_q    <= 1'b0;
            mem_data_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            f3_q       <= f3_d;
            store_q    <= store_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Bus controls decode straight from the state register, so reset drops them at once.
    assign bus_req   = (state_q == REQ);
    assign bus_we    = bus_req & store_q;
    assign bus_wstrb = bus_req ? wstrb_q : 4'b0000;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign done      = (state_q == DONE) | (state_q == FAULT);
    assign fault     = (state_q == FAULT);
    assign mem_data  = mem_data_q;
    assign stall     = ((state_q == IDLE) && start && mem_op_s) || (state_q == REQ);

endmodule
